// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types for the pipelined MIPS core.
package cpu_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_LUI = 2'd3} wb_sel_t;
  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} wb_state_t;
endpackage

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB latch, write-back mux, register-file write, bypass, halt and retire count.
module writeback_stage
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             flush,
  input  logic             valid_i,
  input  logic             regwr_i,
  input  logic [4:0]       wsel_i,
  input  logic [1:0]       wbsel_i,
  input  logic [31:0]      alu_i,
  input  logic [31:0]      dload_i,
  input  logic [31:0]      pcp4_i,
  input  logic [15:0]      imm16_i,
  input  logic             halt_i,
  output logic             WEN,
  output logic [4:0]       wsel,
  output logic [31:0]      wdat,
  output logic             fwd_valid,
  output logic [4:0]       fwd_sel,
  output logic [31:0]      fwd_dat,
  output logic             halt_o,
  output logic [CNT_W-1:0] retired
);
  wb_state_t        state;
  wb_sel_t          sel;
  logic             wen_q;
  regbits_t         wsel_q;
  word_t            wdat_q, wb_dat;
  logic [CNT_W-1:0] ret_q;
  always_comb begin
    sel    = wb_sel_t'(wbsel_i);
    wb_dat = (sel == WB_ALU) ? alu_i :
             (sel == WB_MEM) ? dload_i :
             (sel == WB_PC4) ? pcp4_i : {imm16_i, 16'h0};
  end
  // HALTED freezes everything; wen_q was cleared on the edge that entered it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state  <= RUN;
      wen_q  <= 1'b0;
      wsel_q <= '0;
      wdat_q <= '0;
      ret_q  <= '0;
    end else if (state == RUN) begin
      if (flush) begin
        wen_q <= 1'b0;
      end else if (en) begin
        wsel_q <= wsel_i;
        wdat_q <= wb_dat;
        ret_q  <= ret_q + {{(CNT_W-1){1'b0}}, valid_i};
        if (valid_i && halt_i) begin
          state <= HALTED;
          wen_q <= 1'b0;
        end else begin
          wen_q <= valid_i & regwr_i & (wsel_i != 5'd0);
        end
      end
    end
  end
  assign WEN       = wen_q;
  assign wsel      = wsel_q;
  assign wdat      = wdat_q;
  assign fwd_valid = wen_q;
  assign fwd_sel   = wsel_q;
  assign fwd_dat   = wdat_q;
  assign halt_o    = (state == HALTED);
  assign retired   = ret_q;
endmodule
